ifetch_resp: RTL and testbench
==============================

# ifetch_resp

Instruction-fetch responder for the pipelined core: the memory-side end of the fetch interface whose requester presents `pc` and holds it until `instr_valid` is returned. It answers each fetch with one 32-bit instruction from a one-entry, 64-bit line buffer, or by issuing a read on a 64-bit instruction-memory port. It flags misaligned PCs and bus errors as faults instead of hanging the front end.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`: value driven on `instr` for faulted responses and while idle.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `pc  in  64`: fetch address. The requester holds it stable from request until the cycle after `instr_valid`.
- `inv  in  1`: invalidate the line buffer (fence.i).
- `instr  out  32`: returned instruction. Valid only while `instr_valid` is high.
- `instr_valid  out  1`: single-cycle response strobe.
- `instr_fault  out  1`: qualifies `instr_valid`. Set for a misaligned PC or a bus error.
- `mem_req  out  1`: memory read request.
- `mem_addr  out  64`: 8-byte-aligned read address, `{pc[63:3],3'b000}`.
- `mem_gnt  in  1`: request accepted this cycle.
- `mem_rvalid  in  1`: read data valid.
- `mem_rdata  in  64`: read data, little-endian.
- `mem_err  in  1`: qualifies `mem_rvalid`; marks a bus error.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE evaluates `pc` every cycle, in priority order:
  - `pc[1:0]!=0`: go to RESP with fault.
  - Else `inv`: go to REQ (`inv` overrides a hit).
  - Else `buf_valid && pc[63:3]==buf_tag`: go to RESP with a hit.
  - Else: go to REQ.
- REQ:
  - Drive `mem_req=1` and `mem_addr`. Latch `req_hi=pc[2]` and `req_tag=pc[63:3]` on entry.
  - Hold the request until `mem_gnt`, then go to WAIT.
- WAIT: `mem_req=0`. On `mem_rvalid`:
  - `!mem_err`: write `buf_data=mem_rdata` and `buf_tag=req_tag`. Set `buf_valid=1` unless `inv` was seen during REQ or WAIT. Go to RESP.
  - `mem_err`: `buf_valid=0`; go to RESP with fault.
- RESP: `instr_valid=1` for exactly one cycle, then return to IDLE.
  - Normal response: `instr = req_hi ? data[63:32] : data[31:0]`, `instr_fault=0`.
  - Faulted response: `instr=NOP_INSTR`, `instr_fault=1`.
- `inv` outside REQ/WAIT clears `buf_valid` at the next edge.
- Only one fetch is outstanding at a time. The memory may not return `mem_rvalid` in the same cycle as `mem_gnt`.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `instr=NOP_INSTR`, `instr_valid=0`, `instr_fault=0`, `mem_req=0`, `mem_addr=0`, `buf_valid=0`.
- Hit or misaligned PC: `pc` sampled in IDLE at cycle t; `instr_valid` high in cycle t+1.
- Miss: `mem_req` high in t+1. With `mem_gnt` in t+1 and `mem_rvalid` in t+2, `instr_valid` is high in t+3. Each wait cycle on `mem_gnt` or `mem_rvalid` adds one cycle.
- Throughput is at most one response per 2 cycles, because the new `pc` is visible the cycle after RESP.
- Asserting `rst` mid-fetch: return to IDLE and drop the buffer. The memory shares `rst`, so no stale `mem_rvalid` arrives afterwards.
- `mem_rvalid` outside WAIT is ignored. A checker must flag it.

## Structure
- Package `ifetch_pkg`:
  - state enum `ifr_state_t`;
  - `NOP_INSTR` and `FETCH_ALIGN=3` constants.
- Optional sub-module `ifetch_linebuf` holds tag, data and valid, and provides the hit compare and the 32-bit half select. The FSM stays in `ifetch_resp`.

## Test plan
- Cold fetch at `pc=64'h8000_0000`, `mem_rdata=64'h0010_0093_0000_0513`, gnt and rvalid immediate -> `instr_valid` high in t+3, `instr=32'h0000_0513`, `instr_fault=0`.
- Follow-up fetch `pc=64'h8000_0004` -> hit: `instr_valid` in t+1, `instr=32'h0010_0093`, no `mem_req`.
- `pc=64'h8000_0002` -> `instr_valid=1`, `instr_fault=1`, `instr=32'h13` in t+1, no `mem_req`.
- `mem_err=1` with `mem_rvalid` -> fault response. A refetch of the same line issues `mem_req` (buffer invalid).
- `inv` pulsed during WAIT -> data still returned; the next fetch of the same line misses.
- `rst` asserted while in WAIT -> all outputs take their reset values immediately. After release, a fetch of `64'h8000_0000` misses.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Line buffer geometry and the response-half select live here.
package ifetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } ifr_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int FETCH_ALIGN = 3;
  localparam int TAG_W = 64 - FETCH_ALIGN;

  function automatic logic [31:0] half_sel(
    input logic [63:0] d,
    input logic        hi
  );
    return hi ? d[63:32] : d[31:0];
  endfunction

endpackage

// File: rtl/ifetch_linebuf.sv
// One-entry 64-bit instruction line buffer.
// Provides the tag hit compare and the 32-bit half select.
module ifetch_linebuf
  import ifetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fill,
  input  logic             fill_keep,
  input  logic             kill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [63:0]      fill_data,
  input  logic [TAG_W-1:0] look_tag,
  input  logic             look_hi,
  output logic             hit,
  output logic [31:0]      look_instr
);

  logic [TAG_W-1:0] tag;
  logic [63:0]      data;
  logic             valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag   <= '0;
      data  <= '0;
      valid <= 1'b0;
    end else if (fill) begin
      tag   <= fill_tag;
      data  <= fill_data;
      valid <= fill_keep;
    end else if (kill) begin
      valid <= 1'b0;
    end
  end

  assign hit        = valid && (look_tag == tag);
  assign look_instr = half_sel(data, look_hi);

endmodule

// File: rtl/ifetch_resp.sv
// Instruction-fetch responder: answers each fetch from the line
// buffer or via a 64-bit memory read; faults misaligned PCs.
module ifetch_resp
  import ifetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc,
  input  logic        inv,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        instr_fault,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  ifr_state_t       state;
  logic             req_hi;
  logic [TAG_W-1:0] req_tag;
  logic             inv_seen;
  logic             misalign;
  logic             in_mem;
  logic             rsp_ok;
  logic             rsp_err;
  logic             hit;
  logic [31:0]      buf_instr;

  assign misalign = pc[1:0] != 2'b00;
  assign in_mem   = (state == S_REQ) || (state == S_WAIT);
  assign rsp_ok   = (state == S_WAIT) && mem_rvalid && !mem_err;
  assign rsp_err  = (state == S_WAIT) && mem_rvalid && mem_err;

  // inv seen while the read was in flight makes the fill stale
  ifetch_linebuf u_buf (
    .clk        (clk),
    .rst        (rst),
    .fill       (rsp_ok),
    .fill_keep  (!(inv_seen || inv)),
    .kill       (rsp_err || (inv && !in_mem)),
    .fill_tag   (req_tag),
    .fill_data  (mem_rdata),
    .look_tag   (pc[63:FETCH_ALIGN]),
    .look_hi    (pc[2]),
    .hit        (hit),
    .look_instr (buf_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      req_hi      <= 1'b0;
      req_tag     <= '0;
      inv_seen    <= 1'b0;
    end else begin
      instr       <= NOP_INSTR;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            misalign: begin
              state       <= S_RESP;
              instr_valid <= 1'b1;
              instr_fault <= 1'b1;
            end
            !misalign && !inv && hit: begin
              state       <= S_RESP;
              instr_valid <= 1'b1;
              instr       <= buf_instr;
            end
            default: begin
              state    <= S_REQ;
              mem_req  <= 1'b1;
              mem_addr <= {pc[63:FETCH_ALIGN], {FETCH_ALIGN{1'b0}}};
              req_hi   <= pc[2];
              req_tag  <= pc[63:FETCH_ALIGN];
              inv_seen <= 1'b0;
            end
          endcase
        end
        S_REQ: begin
          inv_seen <= inv_seen || inv;
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          inv_seen <= inv_seen || inv;
          if (mem_rvalid) begin
            state       <= S_RESP;
            instr_valid <= 1'b1;
            instr_fault <= mem_err;
            instr       <= mem_err ? NOP_INSTR
                                   : half_sel(mem_rdata, req_hi);
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  a_rvalid_in_wait: assert property (
    @(posedge clk) disable iff (rst) mem_rvalid |-> state == S_WAIT
  );

endmodule

// File: tb/tb_ifetch_resp.sv
// Self-checking bench for ifetch_resp: vector table driven through a
// reactive memory model, with a scoreboard of expected responses.
module tb_ifetch_resp;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc;
  logic        inv;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_fault;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        mem_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] pc;
    bit          inv;
    bit          inv_wait;
    int          gd;
    int          rd;
    logic [63:0] rdata;
    bit          err;
    logic [31:0] exp_instr;
    bit          exp_fault;
    bit          exp_miss;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  ifetch_resp dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .inv         (inv),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_fault (instr_fault),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [63:0] pc_i, input bit inv_i, input bit invw_i,
    input int gd_i, input int rd_i, input logic [63:0] rdata_i,
    input bit err_i, input logic [31:0] ei, input bit ef, input bit em
  );
    vec_t v;
    v.pc = pc_i; v.inv = inv_i; v.inv_wait = invw_i;
    v.gd = gd_i; v.rd = rd_i; v.rdata = rdata_i; v.err = err_i;
    v.exp_instr = ei; v.exp_fault = ef; v.exp_miss = em;
    return v;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr"}, {32'h0, instr}, {32'h0, NOP_INSTR});
    chk({tag, "_valid"}, {63'h0, instr_valid}, 64'h0);
    chk({tag, "_fault"}, {63'h0, instr_fault}, 64'h0);
    chk({tag, "_req"}, {63'h0, mem_req}, 64'h0);
    chk({tag, "_addr"}, mem_addr, 64'h0);
  endtask

  // Entered and left at 1 time unit after a rising edge with the DUT idle.
  task automatic run_vec(input vec_t v, input int idx);
    int n = 0;
    int gc = 0;
    int rc = 0;
    bit granted = 0;
    bit rvd = 0;
    bit saw = 0;
    bit done = 0;
    int lat;
    exp_t e;
    string nm;
    lat = v.exp_miss ? 3 + v.gd + v.rd : 1;
    pc  = v.pc;
    inv = v.inv;
    sb.push_back('{v.exp_instr, v.exp_fault});
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      inv = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      mem_err = 1'b0; mem_rdata = '0;
      if (instr_valid) begin
        done = 1;
        if (sb.size() == 0) begin
          nm = $sformatf("v%0d_sb_empty", idx);
          chk(nm, 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          nm = $sformatf("v%0d_instr", idx);
          chk(nm, {32'h0, instr}, {32'h0, e.instr});
          nm = $sformatf("v%0d_fault", idx);
          chk(nm, {63'h0, instr_fault}, {63'h0, e.fault});
        end
        nm = $sformatf("v%0d_latency", idx);
        chk(nm, 64'(n), 64'(lat));
        nm = $sformatf("v%0d_mem_req_seen", idx);
        chk(nm, {63'h0, saw}, {63'h0, v.exp_miss});
      end else if (granted && !rvd) begin
        if (v.inv_wait && rc == 0) inv = 1'b1;
        if (rc == v.rd) begin
          mem_rvalid = 1'b1;
          mem_rdata  = v.rdata;
          mem_err    = v.err;
          rvd = 1;
        end else begin
          rc++;
        end
      end else if (mem_req) begin
        if (!saw) begin
          nm = $sformatf("v%0d_mem_addr", idx);
          chk(nm, mem_addr, {v.pc[63:3], 3'b000});
        end
        saw = 1;
        if (gc == v.gd) begin
          mem_gnt = 1'b1;
          granted = 1;
        end else begin
          gc++;
        end
      end
    end
    if (!done) begin
      nm = $sformatf("v%0d_timeout", idx);
      chk(nm, 64'd0, 64'd1);
      void'(sb.pop_back());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; pc = '0; inv = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    #1;
    chk_reset_outputs("rst_async");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_held");
    rst = 1'b0;

    vt.push_back(mk(64'h8000_0000, 0, 0, 0, 0, 64'h0010_0093_0000_0513,
                    0, 32'h0000_0513, 0, 1));
    vt.push_back(mk(64'h8000_0004, 0, 0, 0, 0, 64'h0,
                    0, 32'h0010_0093, 0, 0));
    vt.push_back(mk(64'h8000_0002, 0, 0, 0, 0, 64'h0,
                    0, NOP_INSTR, 1, 0));
    vt.push_back(mk(64'h8000_0008, 0, 0, 2, 1, 64'hAAAA_BBBB_CCCC_DDDD,
                    0, 32'hCCCC_DDDD, 0, 1));
    vt.push_back(mk(64'h8000_000C, 0, 0, 0, 0, 64'h0,
                    0, 32'hAAAA_BBBB, 0, 0));
    vt.push_back(mk(64'h8000_0000, 0, 0, 0, 0, 64'h1111_2222_3333_4444,
                    0, 32'h3333_4444, 0, 1));
    vt.push_back(mk(64'h8000_0010, 0, 0, 1, 0, 64'hDEAD_BEEF_DEAD_BEEF,
                    1, NOP_INSTR, 1, 1));
    vt.push_back(mk(64'h8000_0010, 0, 0, 0, 0, 64'h5555_6666_7777_8888,
                    0, 32'h7777_8888, 0, 1));
    vt.push_back(mk(64'h8000_0014, 0, 0, 0, 0, 64'h0,
                    0, 32'h5555_6666, 0, 0));
    vt.push_back(mk(64'h8000_0014, 1, 0, 0, 0, 64'h9999_0000_1234_5678,
                    0, 32'h9999_0000, 0, 1));
    vt.push_back(mk(64'h8000_0018, 0, 1, 0, 1, 64'h2222_3333_4444_5555,
                    0, 32'h4444_5555, 0, 1));
    vt.push_back(mk(64'h8000_001C, 0, 0, 0, 0, 64'h6666_7777_8888_9999,
                    0, 32'h6666_7777, 0, 1));
    vt.push_back(mk(64'h8000_0018, 0, 0, 0, 0, 64'h0,
                    0, 32'h8888_9999, 0, 0));
    vt.push_back(mk(64'h8000_0001, 1, 0, 0, 0, 64'h0,
                    0, NOP_INSTR, 1, 0));
    vt.push_back(mk(64'h8000_0018, 0, 0, 0, 0, 64'h0123_4567_89AB_CDEF,
                    0, 32'h89AB_CDEF, 0, 1));
    vt.push_back(mk(64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, 2,
                    64'h0BAD_F00D_CAFE_0001, 0, 32'hCAFE_0001, 0, 1));
    vt.push_back(mk(64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 64'h0,
                    0, 32'h0BAD_F00D, 0, 0));

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // Reset while waiting on read data drops the fetch and the buffer.
    pc = 64'h8000_0000;
    @(posedge clk); #1;
    chk("mid_rst_req", {63'h0, mem_req}, 64'h1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    chk("mid_rst_wait_req", {63'h0, mem_req}, 64'h0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(mk(64'h8000_0000, 0, 0, 0, 0, 64'h7777_0000_4321_8765,
               0, 32'h4321_8765, 0, 1), 100);
    run_vec(mk(64'h8000_0004, 0, 0, 0, 0, 64'h0,
               0, 32'h7777_0000, 0, 0), 101);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
